// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and data access
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [7:0]  err_count
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_starve_cnt;
    logic [7:0]    r_err_count;

    logic w_dreq;
    logic w_access;
    logic w_error;
    logic w_igrant;
    logic w_dgrant;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == RAM_ACCESS);
    assign w_error  = (ramstate == RAM_ERROR);
    assign w_igrant = (r_state == IGNT) & iREN;
    assign w_dgrant = (r_state == DGNT) & w_dreq;

    // RAM drive follows the live request so a dropped request releases the RAM immediately
    assign ramREN    = w_igrant | ((r_state == DGNT) & dREN);
    assign ramWEN    = (r_state == DGNT) & dWEN;
    assign ramaddr   = (r_state == DGNT) ? daddr : iaddr;
    assign ramstore  = dstore;
    assign iload     = ramload;
    assign dload     = ramload;
    assign iwait     = ~(w_igrant & w_access);
    assign dwait     = ~(w_dgrant & w_access);
    assign err_count = r_err_count;

    // Grant FSM: latch one owner per transaction, retry on ERROR, fairness via starve counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_err_count  <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!iREN) begin
                        r_starve_cnt <= '0;
                    end
                    if (w_dreq && iREN) begin
                        r_state <= (r_starve_cnt == SMAX) ? IGNT : DGNT;
                    end else if (w_dreq) begin
                        r_state <= DGNT;
                    end else if (iREN) begin
                        r_state <= IGNT;
                    end
                end
                IGNT: begin
                    if (!iREN) begin
                        r_state <= IDLE;
                    end else if (w_access) begin
                        r_state      <= IDLE;
                        r_starve_cnt <= '0;
                    end else if (w_error && (r_err_count != 8'hFF)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                DGNT: begin
                    if (!w_dreq) begin
                        r_state <= IDLE;
                    end else if (w_access) begin
                        r_state <= IDLE;
                        if (iREN && (r_starve_cnt != SMAX)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_error && (r_err_count != 8'hFF)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // model: who owns the RAM (0 none, 1 instruction, 2 data), fairness count, error count
    int    m_own    = 0;
    int    m_starve = 0;
    int    m_err    = 0;
    string dut_log  = "";
    string mdl_log  = "";

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // per-cycle comparison against the model, then advance the model across the coming edge
    always @(negedge CLK) begin
        logic dreq;
        logic acc;
        logic e_ren;
        logic e_wen;
        if (!nRST) begin
            chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
            chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
            chk("rst_iwait", {31'd0, iwait}, 32'd1);
            chk("rst_dwait", {31'd0, dwait}, 32'd1);
            chk("rst_err", {24'd0, err_count}, 32'd0);
            m_own = 0; m_starve = 0; m_err = 0;
        end else begin
            dreq  = dREN | dWEN;
            acc   = (ramstate == 2'd2);
            e_ren = (m_own == 1 && iREN) || (m_own == 2 && dREN);
            e_wen = (m_own == 2 && dWEN);
            chk("m_ramREN", {31'd0, ramREN}, {31'd0, e_ren});
            chk("m_ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
            chk("m_ramaddr", ramaddr, (m_own == 2) ? daddr : iaddr);
            chk("m_ramstore", ramstore, dstore);
            chk("m_iload", iload, ramload);
            chk("m_dload", dload, ramload);
            chk("m_iwait", {31'd0, iwait}, {31'd0, !(m_own == 1 && iREN && acc)});
            chk("m_dwait", {31'd0, dwait}, {31'd0, !(m_own == 2 && dreq && acc)});
            chk("m_err", {24'd0, err_count}, m_err);
            chk("m_starve", 32'(dut.r_starve_cnt), m_starve);
            if (!iwait) dut_log = {dut_log, "I"};
            if (!dwait) dut_log = {dut_log, "D"};
            case (m_own)
                0: begin
                    if (!iREN) m_starve = 0;
                    if (dreq && iREN) m_own = (m_starve == SMAX) ? 1 : 2;
                    else if (dreq) m_own = 2;
                    else if (iREN) m_own = 1;
                end
                1: begin
                    if (!iREN) m_own = 0;
                    else if (acc) begin
                        mdl_log = {mdl_log, "I"};
                        m_own = 0; m_starve = 0;
                    end else if (ramstate == 2'd3 && m_err < 255) m_err++;
                end
                default: begin
                    if (!dreq) m_own = 0;
                    else if (acc) begin
                        mdl_log = {mdl_log, "D"};
                        m_own = 0;
                        if (iREN && m_starve < SMAX) m_starve++;
                    end else if (ramstate == 2'd3 && m_err < 255) m_err++;
                end
            endcase
        end
    end

    initial begin
        nRST = 1'b0; iREN = 0; iaddr = 32'h0; dREN = 0; dWEN = 0;
        daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = 2'd0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        chk("reset_err", {24'd0, err_count}, 32'd0);
        chk("reset_iwait", {31'd0, iwait}, 32'd1);
        chk("reset_dwait", {31'd0, dwait}, 32'd1);

        // instruction only, ACCESS two cycles after grant
        iREN = 1; iaddr = 32'h40; ramstate = 2'd0;
        step();
        ramstate = 2'd1;
        #1 chk("t1_grant_ren", {31'd0, ramREN}, 32'd1);
        chk("t1_grant_iwait", {31'd0, iwait}, 32'd1);
        step();
        step();
        ramstate = 2'd2; ramload = 32'h8C010004;
        #1 chk("t1_iwait_low", {31'd0, iwait}, 32'd0);
        chk("t1_iload", iload, 32'h8C010004);
        step();
        iREN = 0; ramstate = 2'd0;
        #1 chk("t1_idle_ren", {31'd0, ramREN}, 32'd0);
        chk("t1_idle_iwait", {31'd0, iwait}, 32'd1);
        step();

        // contention: write wins first, instruction afterwards
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        step();
        ramstate = 2'd2;
        #1 chk("t2_wen", {31'd0, ramWEN}, 32'd1);
        chk("t2_ren", {31'd0, ramREN}, 32'd0);
        chk("t2_addr", ramaddr, 32'h100);
        chk("t2_store", ramstore, 32'hDEADBEEF);
        chk("t2_dwait", {31'd0, dwait}, 32'd0);
        step();
        dWEN = 0; ramstate = 2'd0;
        step();
        ramstate = 2'd2;
        #1 chk("t2_igrant_ren", {31'd0, ramREN}, 32'd1);
        chk("t2_igrant_addr", ramaddr, 32'h44);
        chk("t2_iwait", {31'd0, iwait}, 32'd0);
        step();
        iREN = 0; ramstate = 2'd0;
        step();

        // starvation guard: both held, RAM always ready
        dut_log = ""; mdl_log = "";
        iREN = 1; dREN = 1; daddr = 32'h200; ramstate = 2'd2;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) chk("t3_starve_zero", 32'(dut.r_starve_cnt), 32'd0);
            step();
        end
        iREN = 0; dREN = 0; ramstate = 2'd0;
        checks++;
        if (dut_log != "DDDDID") begin
            errors++;
            $display("FAIL t3_order_dut: got %s expected DDDDID", dut_log);
        end
        checks++;
        if (mdl_log != "DDDDID") begin
            errors++;
            $display("FAIL t3_order_model: got %s expected DDDDID", mdl_log);
        end
        step();

        // error retry then saturation
        dREN = 1; daddr = 32'h300; ramstate = 2'd3;
        step();
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_dwait_err", {31'd0, dwait}, 32'd1);
            step();
        end
        ramstate = 2'd2;
        #1 chk("t4_err3", {24'd0, err_count}, 32'd3);
        chk("t4_done", {31'd0, dwait}, 32'd0);
        step();
        ramstate = 2'd3;
        step();
        repeat (300) step();
        chk("t4_sat", {24'd0, err_count}, 32'd255);
        dREN = 0; ramstate = 2'd0;
        step();

        // abort: data request dropped mid-grant, pending instruction follows
        dREN = 1; iREN = 1; iaddr = 32'h80; daddr = 32'h400; ramstate = 2'd1;
        step();
        #1 chk("t5_dgnt_ren", {31'd0, ramREN}, 32'd1);
        chk("t5_dgnt_addr", ramaddr, 32'h400);
        dREN = 0;
        #1 chk("t5_abort_ren", {31'd0, ramREN}, 32'd0);
        step();
        #1 chk("t5_idle_ren", {31'd0, ramREN}, 32'd0);
        step();
        #1 chk("t5_igrant_ren", {31'd0, ramREN}, 32'd1);
        chk("t5_igrant_addr", ramaddr, 32'h80);

        // reset during an instruction BUSY wait
        #1 nRST = 1'b0;
        #1 chk("t6_ren", {31'd0, ramREN}, 32'd0);
        chk("t6_iwait", {31'd0, iwait}, 32'd1);
        chk("t6_dwait", {31'd0, dwait}, 32'd1);
        chk("t6_err", {24'd0, err_count}, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        #1 chk("t6_idle_ren", {31'd0, ramREN}, 32'd0);
        step();
        #1 chk("t6_regrant", {31'd0, ramREN}, 32'd1);
        iREN = 0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
